m_receiver: RTL and testbench

Frame receiver for the single-wire Manchester link driven by `m_transmitter`. It recovers bits from the oversampled `i_rx` line, locks to the preamble and sync byte, and parses the 16-bit length header. Payload bytes stream out with a one-cycle valid strobe, and the block keeps good-frame and error statistics. It sits on the CPLD input side, mirroring the transmitter, and feeds the byte consumer directly with no backpressure.

---
 rtl/m_receiver.sv | 263 ++++++++++++++++++++++++++
 tb/tb_m_receiver.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/m_receiver.sv
// Manchester frame receiver: bit recovery, sync lock, length header, payload strobes, stats.
// Optional CRC-8 trailer check is built when M_RECEIVER_CRC8_EN is defined.
module m_receiver #(
  parameter int BIT_CYCLES = 8,
  parameter int MAX_LEN    = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx,
  output logic [7:0]  o_data,
  output logic        o_data_valid,
  output logic        o_frame_start,
  output logic        o_frame_done,
  output logic        o_frame_err,
  output logic [15:0] o_data_size,
  output logic [7:0]  o_frames_count,
  output logic [7:0]  o_status
);

  localparam int CW = $clog2(2 * BIT_CYCLES);
  localparam logic [CW-1:0] Q3 = CW'(3 * BIT_CYCLES / 4);
  localparam logic [CW-1:0] Q5 = CW'(5 * BIT_CYCLES / 4);
  localparam logic [16:0] MAXL = 17'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE, S_HUNT, S_LEN_LO, S_LEN_HI,
    S_PAYLOAD, S_CRC, S_DONE, S_ERR
  } state_e;

`ifdef M_RECEIVER_CRC8_EN
  localparam state_e S_TAIL = S_CRC;
`else
  localparam state_e S_TAIL = S_DONE;
`endif

  logic          rx_s1_q, rx_s2_q, rx_prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lock_q, lock_d;
  logic          bit_v, bit_val, tmo, rx_edge;

  state_e        state_q, state_d;
  logic [7:0]    sh_q, sh_d, nxt_sh;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    lenlo_q, lenlo_d;
  logic [15:0]   rem_q, rem_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          start_q, start_d;
  logic [15:0]   size_q, size_d;
  logic [7:0]    fcnt_q, fcnt_d;
  logic [4:0]    status_q, status_d;
  logic [2:0]    cause_q, cause_d;
  logic          drain_q, drain_d;

`ifdef M_RECEIVER_CRC8_EN
  logic [7:0]    crc_q, crc_d;

  function automatic logic [7:0] crc8(input logic [7:0] c,
                                      input logic [7:0] d);
    logic [7:0] x;
    x = c ^ d;
    for (int i = 0; i < 8; i++)
      x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
    return x;
  endfunction
`endif

  assign rx_edge = rx_s2_q ^ rx_prev_q;
  assign bit_val = rx_s2_q;
  assign nxt_sh  = {bit_val, sh_q[7:1]};

  // Mid-bit edge tracker: boundary edges fall before the 3/4 window.
  always_comb begin
    bit_v  = 1'b0;
    tmo    = 1'b0;
    lock_d = lock_q;
    cnt_d  = cnt_q;
    if (!lock_q) begin
      cnt_d = '0;
      if (rx_edge) begin
        bit_v  = 1'b1;
        lock_d = 1'b1;
      end
    end else if (cnt_q > Q5) begin
      tmo    = 1'b1;
      lock_d = 1'b0;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
      if (rx_edge && cnt_q >= Q3) begin
        bit_v = 1'b1;
        cnt_d = '0;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    sh_d     = sh_q;
    bcnt_d   = bcnt_q;
    lenlo_d  = lenlo_q;
    rem_d    = rem_q;
    data_d   = data_q;
    size_d   = size_q;
    fcnt_d   = fcnt_q;
    status_d = status_q;
    cause_d  = cause_q;
    drain_d  = tmo ? 1'b0 : drain_q;
    valid_d  = 1'b0;
    start_d  = 1'b0;
`ifdef M_RECEIVER_CRC8_EN
    crc_d    = crc_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bit_v && !drain_q) begin
          sh_d    = nxt_sh;
          state_d = S_HUNT;
        end
      end
      S_HUNT: begin
        if (tmo) begin
          state_d = S_IDLE;
        end else if (bit_v) begin
          sh_d = nxt_sh;
          if (nxt_sh == 8'hD5) begin
            start_d     = 1'b1;
            status_d[0] = 1'b1;
            bcnt_d      = '0;
            state_d     = S_LEN_LO;
`ifdef M_RECEIVER_CRC8_EN
            crc_d       = '0;
`endif
          end
        end
      end
      S_LEN_LO, S_LEN_HI, S_PAYLOAD: begin
        if (tmo) begin
          cause_d = 3'b001;
          state_d = S_ERR;
        end else if (bit_v) begin
          sh_d   = nxt_sh;
          bcnt_d = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) begin
`ifdef M_RECEIVER_CRC8_EN
            crc_d = crc8(crc_q, nxt_sh);
`endif
            if (state_q == S_LEN_LO) begin
              lenlo_d = nxt_sh;
              state_d = S_LEN_HI;
            end else if (state_q == S_LEN_HI) begin
              size_d = {nxt_sh, lenlo_q};
              rem_d  = size_d;
              if ({1'b0, size_d} > MAXL) begin
                cause_d = 3'b010;
                state_d = S_ERR;
              end else if (size_d == 16'd0) begin
                state_d = S_TAIL;
              end else begin
                state_d = S_PAYLOAD;
              end
            end else begin
              data_d  = nxt_sh;
              valid_d = 1'b1;
              rem_d   = rem_q - 16'd1;
              if (rem_d == 16'd0) state_d = S_TAIL;
            end
          end
        end
      end
`ifdef M_RECEIVER_CRC8_EN
      S_CRC: begin
        if (tmo) begin
          cause_d = 3'b001;
          state_d = S_ERR;
        end else if (bit_v) begin
          sh_d   = nxt_sh;
          bcnt_d = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) begin
            if (nxt_sh == crc_q) begin
              state_d = S_DONE;
            end else begin
              cause_d = 3'b100;
              state_d = S_ERR;
            end
          end
        end
      end
`endif
      S_DONE: begin
        fcnt_d   = fcnt_q + 8'd1;
        status_d = 5'b00010;
        drain_d  = 1'b1;
        state_d  = S_IDLE;
      end
      S_ERR: begin
        status_d = {cause_q, 2'b00};
        // A timeout already means the line is idle; nothing left to drain.
        drain_d  = ~cause_q[0];
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_s1_q   <= 1'b0;
      rx_s2_q   <= 1'b0;
      rx_prev_q <= 1'b0;
      cnt_q     <= '0;
      lock_q    <= 1'b0;
      state_q   <= S_IDLE;
      sh_q      <= '0;
      bcnt_q    <= '0;
      lenlo_q   <= '0;
      rem_q     <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      start_q   <= 1'b0;
      size_q    <= '0;
      fcnt_q    <= '0;
      status_q  <= '0;
      cause_q   <= '0;
      drain_q   <= 1'b0;
`ifdef M_RECEIVER_CRC8_EN
      crc_q     <= '0;
`endif
    end else begin
      rx_s1_q   <= i_rx;
      rx_s2_q   <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
      cnt_q     <= cnt_d;
      lock_q    <= lock_d;
      state_q   <= state_d;
      sh_q      <= sh_d;
      bcnt_q    <= bcnt_d;
      lenlo_q   <= lenlo_d;
      rem_q     <= rem_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      start_q   <= start_d;
      size_q    <= size_d;
      fcnt_q    <= fcnt_d;
      status_q  <= status_d;
      cause_q   <= cause_d;
      drain_q   <= drain_d;
`ifdef M_RECEIVER_CRC8_EN
      crc_q     <= crc_d;
`endif
    end
  end

  assign o_data         = data_q;
  assign o_data_valid   = valid_q;
  assign o_frame_start  = start_q;
  assign o_frame_done   = (state_q == S_DONE);
  assign o_frame_err    = (state_q == S_ERR);
  assign o_data_size    = size_q;
  assign o_frames_count = fcnt_q;
  assign o_status       = {3'b000, status_q};

endmodule

// File: tb/tb_m_receiver.sv
// Directed bench for m_receiver: Manchester frame generator plus strobe monitor.
// Covers reset, nominal, zero length, timeout, length error, CRC error, wrap, mid-frame reset.
module tb_m_receiver;

  localparam int B    = 8;
  localparam int IDLE = 24;
`ifdef M_RECEIVER_CRC8_EN
  localparam int EXP_SAME = 0;
`else
  localparam int EXP_SAME = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        rx;
  logic [7:0]  data;
  logic        dv, fstart, fdone, ferr;
  logic [15:0] dsize;
  logic [7:0]  fcount, status;

  int n_chk = 0;
  int n_pass = 0;
  int exp_cnt = 0;

  int n_valid = 0, n_start = 0, n_done = 0;
  int n_err = 0, n_same = 0, n_both = 0;
  logic [7:0] got[$];
  logic [7:0] pay[0:7];
  logic [7:0] tx_crc;

  always #5 clk = ~clk;

  m_receiver #(.BIT_CYCLES(B), .MAX_LEN(1024)) dut (
    .i_clk(clk), .i_rst(rst), .i_rx(rx),
    .o_data(data), .o_data_valid(dv),
    .o_frame_start(fstart), .o_frame_done(fdone),
    .o_frame_err(ferr), .o_data_size(dsize),
    .o_frames_count(fcount), .o_status(status)
  );

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (dv === 1'b1) begin
        got.push_back(data);
        n_valid++;
      end
      if (fstart === 1'b1) n_start++;
      if (fdone === 1'b1) n_done++;
      if (ferr === 1'b1) n_err++;
      if (fdone === 1'b1 && dv === 1'b1) n_same++;
      if (fdone === 1'b1 && ferr === 1'b1) n_both++;
    end
  end

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] x;
    x = c ^ d;
    for (int i = 0; i < 8; i++)
      x = x[7] ? ((x << 1) ^ 8'h07) : (x << 1);
    return x;
  endfunction

  task automatic send_bit(input logic b);
    rx = ~b;
    repeat (B / 2) @(negedge clk);
    rx = b;
    repeat (B / 2) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic send_head(input int npre, input logic [15:0] len);
    for (int i = 0; i < npre; i++) send_byte(8'h55);
    send_byte(8'hD5);
    tx_crc = 8'h00;
    send_byte(len[7:0]);
    tx_crc = crc8(tx_crc, len[7:0]);
    send_byte(len[15:8]);
    tx_crc = crc8(tx_crc, len[15:8]);
  endtask

  task automatic send_body(input logic [15:0] len, input int nsend,
                           input bit flip, input int idle);
    for (int i = 0; i < nsend; i++) begin
      send_byte(pay[i]);
      tx_crc = crc8(tx_crc, pay[i]);
    end
`ifdef M_RECEIVER_CRC8_EN
    if (nsend == int'(len)) send_byte(flip ? (tx_crc ^ 8'h01) : tx_crc);
`else
    if (flip && len == 16'hFFFF) send_byte(8'h00);
`endif
    rx = 1'b0;
    repeat (idle) @(negedge clk);
  endtask

  task automatic send_frame(input int npre, input logic [15:0] len,
                            input int nsend, input bit flip);
    send_head(npre, len);
    send_body(len, nsend, flip, IDLE);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx  = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (data !== 8'h00) $display("FAIL rst_data: got %h want 00", data); else n_pass++;
    n_chk++; if ({dv, fstart, fdone, ferr} !== 4'b0000) $display("FAIL rst_strobes: got %b want 0000", {dv, fstart, fdone, ferr}); else n_pass++;
    n_chk++; if (dsize !== 16'h0000) $display("FAIL rst_size: got %h want 0000", dsize); else n_pass++;
    n_chk++; if (fcount !== 8'h00) $display("FAIL rst_count: got %h want 00", fcount); else n_pass++;
    n_chk++; if (status !== 8'h00) $display("FAIL rst_status: got %h want 00", status); else n_pass++;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_chk++; if (status !== 8'h00) $display("FAIL rst_status_after: got %h want 00", status); else n_pass++;
  endtask

  task automatic test_nominal;
    int v0, s0, d0, e0, m0;
    v0 = n_valid; s0 = n_start; d0 = n_done; e0 = n_err; m0 = n_same;
    pay[0] = 8'h01; pay[1] = 8'h00; pay[2] = 8'hF4;
    send_head(2, 16'h0003);
    n_chk++; if (status !== 8'h01) $display("FAIL nom_in_frame: got %h want 01", status); else n_pass++;
    send_body(16'h0003, 3, 1'b0, IDLE);
    exp_cnt++;
    n_chk++; if (n_start - s0 !== 1) $display("FAIL nom_start: got %0d want 1", n_start - s0); else n_pass++;
    n_chk++; if (n_valid - v0 !== 3) $display("FAIL nom_valid: got %0d want 3", n_valid - v0); else n_pass++;
    n_chk++; if (got[v0] !== 8'h01) $display("FAIL nom_b0: got %h want 01", got[v0]); else n_pass++;
    n_chk++; if (got[v0+1] !== 8'h00) $display("FAIL nom_b1: got %h want 00", got[v0+1]); else n_pass++;
    n_chk++; if (got[v0+2] !== 8'hF4) $display("FAIL nom_b2: got %h want f4", got[v0+2]); else n_pass++;
    n_chk++; if (n_done - d0 !== 1) $display("FAIL nom_done: got %0d want 1", n_done - d0); else n_pass++;
    n_chk++; if (n_err - e0 !== 0) $display("FAIL nom_err: got %0d want 0", n_err - e0); else n_pass++;
    n_chk++; if (n_same - m0 !== EXP_SAME) $display("FAIL nom_valid_done_same: got %0d want %0d", n_same - m0, EXP_SAME); else n_pass++;
    n_chk++; if (dsize !== 16'h0003) $display("FAIL nom_size: got %h want 0003", dsize); else n_pass++;
    n_chk++; if (fcount !== 8'(exp_cnt)) $display("FAIL nom_count: got %0d want %0d", fcount, exp_cnt); else n_pass++;
    n_chk++; if (status !== 8'h02) $display("FAIL nom_status: got %h want 02", status); else n_pass++;
    n_chk++; if (data !== 8'hF4) $display("FAIL nom_data_hold: got %h want f4", data); else n_pass++;
  endtask

  task automatic test_zero_len;
    int v0, d0;
    v0 = n_valid; d0 = n_done;
    send_frame(2, 16'h0000, 0, 1'b0);
    exp_cnt++;
    n_chk++; if (n_valid - v0 !== 0) $display("FAIL zero_valid: got %0d want 0", n_valid - v0); else n_pass++;
    n_chk++; if (n_done - d0 !== 1) $display("FAIL zero_done: got %0d want 1", n_done - d0); else n_pass++;
    n_chk++; if (fcount !== 8'(exp_cnt)) $display("FAIL zero_count: got %0d want %0d", fcount, exp_cnt); else n_pass++;
    n_chk++; if (dsize !== 16'h0000) $display("FAIL zero_size: got %h want 0000", dsize); else n_pass++;
  endtask

  task automatic test_timeout;
    int v0, d0, e0;
    v0 = n_valid; d0 = n_done; e0 = n_err;
    pay[0] = 8'hA7; pay[1] = 8'h3C;
    send_head(2, 16'h0005);
    send_body(16'h0005, 2, 1'b0, 2 * IDLE);
    n_chk++; if (n_valid - v0 !== 2) $display("FAIL tmo_valid: got %0d want 2", n_valid - v0); else n_pass++;
    n_chk++; if (got[v0+1] !== 8'h3C) $display("FAIL tmo_b1: got %h want 3c", got[v0+1]); else n_pass++;
    n_chk++; if (n_err - e0 !== 1) $display("FAIL tmo_err: got %0d want 1", n_err - e0); else n_pass++;
    n_chk++; if (n_done - d0 !== 0) $display("FAIL tmo_done: got %0d want 0", n_done - d0); else n_pass++;
    n_chk++; if (status !== 8'h04) $display("FAIL tmo_status: got %h want 04", status); else n_pass++;
    n_chk++; if (fcount !== 8'(exp_cnt)) $display("FAIL tmo_count: got %0d want %0d", fcount, exp_cnt); else n_pass++;
  endtask

  task automatic test_len_err;
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    pay[0] = 8'h11; pay[1] = 8'h22;
    send_frame(2, 16'h0401, 2, 1'b0);
    n_chk++; if (n_err - e0 !== 1) $display("FAIL len_err: got %0d want 1", n_err - e0); else n_pass++;
    n_chk++; if (n_valid - v0 !== 0) $display("FAIL len_valid: got %0d want 0", n_valid - v0); else n_pass++;
    n_chk++; if (status !== 8'h08) $display("FAIL len_status: got %h want 08", status); else n_pass++;
    n_chk++; if (dsize !== 16'h0401) $display("FAIL len_size: got %h want 0401", dsize); else n_pass++;
    n_chk++; if (fcount !== 8'(exp_cnt)) $display("FAIL len_count: got %0d want %0d", fcount, exp_cnt); else n_pass++;
  endtask

`ifdef M_RECEIVER_CRC8_EN
  task automatic test_crc_err;
    int v0, d0, e0;
    v0 = n_valid; d0 = n_done; e0 = n_err;
    pay[0] = 8'h01; pay[1] = 8'h00; pay[2] = 8'hF4;
    send_frame(2, 16'h0003, 3, 1'b1);
    n_chk++; if (n_err - e0 !== 1) $display("FAIL crc_err: got %0d want 1", n_err - e0); else n_pass++;
    n_chk++; if (n_done - d0 !== 0) $display("FAIL crc_done: got %0d want 0", n_done - d0); else n_pass++;
    n_chk++; if (n_valid - v0 !== 3) $display("FAIL crc_valid: got %0d want 3", n_valid - v0); else n_pass++;
    n_chk++; if (status !== 8'h10) $display("FAIL crc_status: got %h want 10", status); else n_pass++;
    n_chk++; if (fcount !== 8'(exp_cnt)) $display("FAIL crc_count: got %0d want %0d", fcount, exp_cnt); else n_pass++;
  endtask
`endif

  task automatic test_back_to_back;
    int v0, d0;
    v0 = n_valid; d0 = n_done;
    pay[0] = 8'h5A; pay[1] = 8'hC3;
    send_frame(1, 16'h0002, 2, 1'b0);
    pay[0] = 8'hFF;
    send_frame(3, 16'h0001, 1, 1'b0);
    exp_cnt += 2;
    n_chk++; if (n_done - d0 !== 2) $display("FAIL b2b_done: got %0d want 2", n_done - d0); else n_pass++;
    n_chk++; if (n_valid - v0 !== 3) $display("FAIL b2b_valid: got %0d want 3", n_valid - v0); else n_pass++;
    n_chk++; if (got[v0+1] !== 8'hC3) $display("FAIL b2b_b1: got %h want c3", got[v0+1]); else n_pass++;
    n_chk++; if (got[v0+2] !== 8'hFF) $display("FAIL b2b_b2: got %h want ff", got[v0+2]); else n_pass++;
    n_chk++; if (status !== 8'h02) $display("FAIL b2b_status: got %h want 02", status); else n_pass++;
    n_chk++; if (fcount !== 8'(exp_cnt)) $display("FAIL b2b_count: got %0d want %0d", fcount, exp_cnt); else n_pass++;
  endtask

  task automatic test_wrap;
    while (exp_cnt < 255) begin
      send_frame(1, 16'h0000, 0, 1'b0);
      exp_cnt++;
    end
    n_chk++; if (fcount !== 8'hFF) $display("FAIL wrap_255: got %0d want 255", fcount); else n_pass++;
    send_frame(1, 16'h0000, 0, 1'b0);
    exp_cnt = 0;
    n_chk++; if (fcount !== 8'h00) $display("FAIL wrap_0: got %0d want 0", fcount); else n_pass++;
    n_chk++; if (status !== 8'h02) $display("FAIL wrap_status: got %h want 02", status); else n_pass++;
  endtask

  task automatic test_mid_reset;
    int e0, s0;
    e0 = n_err; s0 = n_start;
    pay[0] = 8'hFF;
    send_head(2, 16'h0003);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst = 1'b1;
    @(negedge clk);
    n_chk++; if (status !== 8'h00) $display("FAIL mrst_status: got %h want 00", status); else n_pass++;
    n_chk++; if (dsize !== 16'h0000) $display("FAIL mrst_size: got %h want 0000", dsize); else n_pass++;
    n_chk++; if (fcount !== 8'h00) $display("FAIL mrst_count: got %0d want 0", fcount); else n_pass++;
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (IDLE) @(negedge clk);
    n_chk++; if (n_start - s0 !== 1) $display("FAIL mrst_start: got %0d want 1", n_start - s0); else n_pass++;
    n_chk++; if (n_err - e0 !== 0) $display("FAIL mrst_err: got %0d want 0", n_err - e0); else n_pass++;
    n_chk++; if (ferr !== 1'b0) $display("FAIL mrst_err_line: got %b want 0", ferr); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b0;
    test_reset;
    test_nominal;
    test_zero_len;
    test_timeout;
    test_len_err;
`ifdef M_RECEIVER_CRC8_EN
    test_crc_err;
`endif
    test_back_to_back;
    test_wrap;
    n_chk++; if (n_both !== 0) $display("FAIL done_err_overlap: got %0d want 0", n_both); else n_pass++;
    test_mid_reset;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
